// File: rtl/exibe_sequencia_if.sv
// Memory/LED bus between the game controller and the sequence playback block.
// ABORT_EN adds the abortar request line.
interface exibe_sequencia_if;
    logic       mostrar;
    logic [3:0] limite;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       exibindo;
    logic       fim_exibicao;
    logic [3:0] db_estado;
`ifdef ABORT_EN
    logic       abortar;

    modport master (output mostrar, limite, dado_mem, abortar,
                    input  endereco, leds, exibindo, fim_exibicao, db_estado);
    modport slave  (input  mostrar, limite, dado_mem, abortar,
                    output endereco, leds, exibindo, fim_exibicao, db_estado);
`else
    modport master (output mostrar, limite, dado_mem,
                    input  endereco, leds, exibindo, fim_exibicao, db_estado);
    modport slave  (input  mostrar, limite, dado_mem,
                    output endereco, leds, exibindo, fim_exibicao, db_estado);
`endif
endinterface

// File: rtl/exibe_sequencia.sv
// Memory-game playback: walks data memory 0..limite, lighting each word for T_ON
// cycles followed by a T_OFF dark gap. Define ABORT_EN to add the abortar input.
module exibe_sequencia #(
    parameter int T_ON    = 1000,
    parameter int T_OFF   = 500,
    parameter int TIMER_W = 12
) (
    input logic              clock,
    input logic              reset,
    exibe_sequencia_if.slave bus
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        AVANCA  = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t              r_estado;
    estado_t              w_proximo;
    logic [TIMER_W-1:0]   r_timer;
    logic [3:0]           r_endereco;
    logic [3:0]           r_limite;
    logic                 w_fim_on;
    logic                 w_fim_off;
    logic                 w_abortar;
    logic [3:0]           w_leds;
    logic                 w_exibindo;
    logic                 w_fim_exibicao;
    logic [3:0]           w_db_estado;

    assign w_fim_on  = (r_timer == TIMER_W'(T_ON - 1));
    assign w_fim_off = (r_timer == TIMER_W'(T_OFF - 1));

`ifdef ABORT_EN
    assign w_abortar = bus.abortar;
`else
    assign w_abortar = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= OCIOSO;
        else       r_estado <= w_proximo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer    <= '0;
            r_endereco <= '0;
            r_limite   <= '0;
        end else begin
            case (r_estado)
                PREPARA: begin
                    r_timer    <= '0;
                    r_endereco <= '0;
                    r_limite   <= bus.limite;
                end
                ACENDE:  r_timer <= w_fim_on  ? '0 : r_timer + 1'b1;
                APAGA:   r_timer <= w_fim_off ? '0 : r_timer + 1'b1;
                AVANCA: begin
                    r_timer    <= '0;
                    r_endereco <= r_endereco + 1'b1;
                end
                default: r_timer <= '0;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_proximo      = r_estado;
        w_leds         = 4'h0;
        w_exibindo     = 1'b1;
        w_fim_exibicao = 1'b0;
        w_db_estado    = {1'b0, r_estado};
        case (r_estado)
            OCIOSO: begin
                w_exibindo = 1'b0;
                if (bus.mostrar) w_proximo = PREPARA;
            end
            PREPARA: w_proximo = ACENDE;
            ACENDE: begin
                w_leds = bus.dado_mem;
                if (w_abortar)     w_proximo = FIM;
                else if (w_fim_on) w_proximo = APAGA;
            end
            APAGA: begin
                if (w_abortar)      w_proximo = FIM;
                else if (w_fim_off) w_proximo = (r_endereco == r_limite) ? FIM : AVANCA;
            end
            AVANCA: w_proximo = w_abortar ? FIM : ACENDE;
            FIM: begin
                w_fim_exibicao = 1'b1;
                w_proximo      = OCIOSO;
            end
            default: begin
                w_db_estado = 4'hF;
                w_proximo   = OCIOSO;
            end
        endcase
    end

    assign bus.endereco     = r_endereco;
    assign bus.leds         = w_leds;
    assign bus.exibindo     = w_exibindo;
    assign bus.fim_exibicao = w_fim_exibicao;
    assign bus.db_estado    = w_db_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia: stimulus queues expected elements and fim
// events, a negedge monitor measures what the DUT actually displays.
module tb_exibe_sequencia;
    localparam int T_ON  = 4;
    localparam int T_OFF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exibe_sequencia_if bus();
    logic [3:0] mem [16];

    assign bus.dado_mem = mem[bus.endereco];

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .TIMER_W(12)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_fim;
        int addr;
        int leds;
        int on_c;
        int off_c;
        int lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int fim_cnt = 0;
    int exp_fims = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0, e0 = 0, prev_st = 0, mon_st = 0;
    bit mon_en = 1'b1;
    bit pend = 1'b0;
    bit p_ok;
    int p_addr, p_leds, p_on, p_off;

    task automatic finalize_elem();
        exp_t e;
        if (sb.size() == 0 || sb[0].is_fim) begin
            checks++; errors++;
            $display("FAIL unexpected element: addr %0d leds %0d, no element expected", p_addr, p_leds);
        end else begin
            e = sb.pop_front();
            check("element addr", p_addr, e.addr);
            check("element leds", p_leds, e.leds);
            check("element on cycles", p_on, e.on_c);
            check("element dark cycles", p_off, e.off_c);
            check("element steady display", int'(p_ok), 1);
        end
        pend = 1'b0;
    endtask

    always @(negedge clk) begin
        mon_st = int'(bus.db_estado);
        cyc++;
        if (bus.fim_exibicao === 1'b1) fim_cnt++;
        if (mon_en && !rst) begin
            if (mon_st == 1 && prev_st != 1) e0 = cyc;
            if (mon_st == 0) pend = 1'b0;
            if (prev_st == 5) begin
                check("fim pulse width state", mon_st, 0);
                check("fim pulse width", int'(bus.fim_exibicao), 0);
            end
            if (mon_st == 2) begin
                if (prev_st != 2) begin
                    if (pend) finalize_elem();
                    p_addr = int'(bus.endereco);
                    p_leds = int'(bus.leds);
                    p_on = 0; p_off = 0; p_ok = 1'b1; pend = 1'b1;
                end
                p_on++;
                if (int'(bus.leds) != p_leds || int'(bus.endereco) != p_addr || bus.exibindo !== 1'b1)
                    p_ok = 1'b0;
            end else if (mon_st == 3 || mon_st == 4) begin
                if (pend) begin
                    p_off++;
                    if (bus.leds !== 4'h0 || bus.exibindo !== 1'b1) p_ok = 1'b0;
                end
            end else if (mon_st == 5) begin
                exp_t e;
                if (pend) finalize_elem();
                if (sb.size() == 0 || !sb[0].is_fim) begin
                    checks++; errors++;
                    $display("FAIL unexpected fim: at cycle %0d, no fim expected", cyc);
                end else begin
                    e = sb.pop_front();
                    check("fim latency", cyc - e0, e.lat);
                    check("fim endereco", int'(bus.endereco), e.addr);
                    check("fim pulse", int'(bus.fim_exibicao), 1);
                    check("fim leds", int'(bus.leds), 0);
                end
            end
        end
        prev_st = mon_st;
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(int l);
        for (int i = 0; i <= l; i++)
            sb.push_back('{1'b0, i, int'(mem[i]), T_ON, (i == l) ? T_OFF : T_OFF + 1, 0});
        sb.push_back('{1'b1, l, 0, 0, 0, 1 + (l + 1) * (T_ON + T_OFF) + l});
    endtask

    task automatic kick(int l);
        @(posedge clk); #1;
        bus.limite  = 4'(l);
        bus.mostrar = 1'b1;
        @(posedge clk); #1;
        bus.mostrar = 1'b0;
    endtask

    task automatic wait_state(int st, int addr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk); #1;
            if (int'(bus.db_estado) == st && int'(bus.endereco) == addr) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_state timeout: state %0d addr %0d never reached", st, addr);
        end
    endtask

    task automatic wait_fim(int n0);
        for (int i = 0; i < 3000 && fim_cnt == n0; i++) @(posedge clk);
        if (fim_cnt == n0) begin
            checks++; errors++;
            $display("FAIL fim timeout: no fim_exibicao pulse, got 0 expected 1");
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic random_mem();
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic run(int l, bit disturb);
        int n0;
        bit ok;
        push_exp(l);
        n0 = fim_cnt;
        kick(l);
        if (disturb) begin
            @(posedge clk); #1;
            bus.limite = 4'($urandom_range(0, 15));
            if (l >= 1) begin
                wait_state(2, 1, ok);
                bus.mostrar = 1'b1;
                @(posedge clk); #1;
                bus.mostrar = 1'b0;
            end
        end
        wait_fim(n0);
        exp_fims++;
    endtask

    initial begin
        bit ok;
        int n0;
        int j;
        logic [3:0] t;
        bus.mostrar = 1'b0;
        bus.limite  = 4'h0;
`ifdef ABORT_EN
        bus.abortar = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);

        repeat (3) @(negedge clk);
        check("reset db_estado", int'(bus.db_estado), 0);
        check("reset leds", int'(bus.leds), 0);
        check("reset endereco", int'(bus.endereco), 0);
        check("reset exibindo", int'(bus.exibindo), 0);
        check("reset fim_exibicao", int'(bus.fim_exibicao), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // single element
        random_mem();
        mem[0] = 4'b0001;
        run(0, 1'b0);

        // three one-hot elements
        random_mem();
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        run(2, 1'b0);

        // full round with 16 distinct words
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = mem[i]; mem[i] = mem[j]; mem[j] = t;
        end
        run(15, 1'b0);

        // mostrar pulse and limite change mid-playback must be ignored
        random_mem();
        run(3, 1'b1);

        for (int k = 0; k < 4; k++) begin
            random_mem();
            run($urandom_range(0, 15), k[0]);
        end

        // reset during apaga of element 1: only element 0 completes, no fim
        random_mem();
        sb.push_back('{1'b0, 0, int'(mem[0]), T_ON, T_OFF + 1, 0});
        n0 = fim_cnt;
        kick(5);
        wait_state(3, 1, ok);
        rst = 1'b1;
        @(negedge clk);
        check("midreset db_estado", int'(bus.db_estado), 0);
        check("midreset leds", int'(bus.leds), 0);
        check("midreset endereco", int'(bus.endereco), 0);
        check("midreset exibindo", int'(bus.exibindo), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check("midreset no fim pulse", fim_cnt, n0);

`ifdef ABORT_EN
        mon_en = 1'b0;
        random_mem();
        n0 = fim_cnt;
        kick(3);
        wait_state(2, 0, ok);
        bus.abortar = 1'b1;
        @(posedge clk); #1;
        bus.abortar = 1'b0;
        check("abort db_estado", int'(bus.db_estado), 5);
        check("abort leds", int'(bus.leds), 0);
        check("abort fim_exibicao", int'(bus.fim_exibicao), 1);
        @(posedge clk); #1;
        check("abort back to ocioso", int'(bus.db_estado), 0);
        check("abort fim cleared", int'(bus.fim_exibicao), 0);
        check("abort single pulse", fim_cnt - n0, 1);
        exp_fims++;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
`endif

        check("scoreboard drained", sb.size(), 0);
        check("total fim pulses", fim_cnt, exp_fims);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
